// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// Module   : instr_fetch_unit_pkg
// Purpose  : Shared widths, reset PC, FSM state type and fetch error codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;

    localparam int PC_SZ    = 32;
    localparam int INSTR_SZ = 32;

    localparam logic [PC_SZ-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_ERROR = 3'd4
    } fetch_state_t;

    localparam logic [1:0] FERR_NONE     = 2'b00;
    localparam logic [1:0] FERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] FERR_MISALIGN = 2'b10;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_watchdog.sv
// ============================================================================
// Module   : fetch_watchdog
// Purpose  : Response watchdog; expire flags the last cycle a response may land.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_watchdog #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Count reaches TIMEOUT_CYC on this edge unless a response wins the same cycle.
    assign expire = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Single-outstanding instruction fetch FSM with PC and hold register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int               PC_W        = PC_SZ,
    parameter int               INSTR_W     = INSTR_SZ,
    parameter logic [PC_W-1:0]  RESET_PC    = DEFAULT_RESET_PC,
    parameter int               TIMEOUT_CYC = 16
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic [PC_W-1:0]    programCounter_o,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    input  logic [PC_W-1:0]    nextProgramCounter_i,
    output logic [1:0]         fetch_err_o
);

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic [PC_W-1:0]     pc;
    logic [INSTR_W-1:0]  instr_q;
    logic [PC_W-1:0]     instr_pc;
    logic [1:0]          err_q;

    logic wd_clear;
    logic wd_enable;
    logic wd_expire;
    logic granted;
    logic response;
    logic retire;
    logic misaligned;

    assign granted    = (state == S_FETCH) && imem_gnt_i;
    assign response   = (state == S_WAIT)  && imem_rvalid_i;
    assign retire     = (state == S_HOLD)  && instr_ready_i;
    assign misaligned = |nextProgramCounter_i[1:0];
    assign wd_clear   = granted;
    assign wd_enable  = (state == S_WAIT);

    fetch_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clock_i),
        .rst_n  (reset_n_i),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Response has priority over watchdog expiry in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: if (imem_gnt_i) state_next = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid_i)  state_next = S_HOLD;
                else if (wd_expire) state_next = S_ERROR;
            end
            S_HOLD: begin
                if (instr_ready_i) state_next = misaligned ? S_ERROR : S_FETCH;
            end
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc       <= RESET_PC;
            instr_q  <= '0;
            instr_pc <= RESET_PC;
            err_q    <= FERR_NONE;
        end else begin
            if (response) begin
                instr_q  <= imem_rdata_i;
                instr_pc <= pc;
            end
            if (retire && !misaligned) begin
                pc <= nextProgramCounter_i;
            end
            if (retire && misaligned) begin
                err_q <= FERR_MISALIGN;
            end else if ((state == S_WAIT) && !imem_rvalid_i && wd_expire) begin
                err_q <= FERR_TIMEOUT;
            end
        end
    end

    assign imem_req_o       = (state == S_FETCH);
    assign imem_addr_o      = pc;
    assign instruction_o    = instr_q;
    assign programCounter_o = instr_pc;
    assign instr_valid_o    = (state == S_HOLD);
    assign fetch_err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Scoreboard bench for instr_fetch_unit with directed fetch vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        valid;
    logic        ready;
    logic [31:0] npc;
    logic [1:0]  err;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        prev_valid = 1'b0;

    instr_fetch_unit #(
        .PC_W        (32),
        .INSTR_W     (32),
        .RESET_PC    (32'h0000_0000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clock_i              (clk),
        .reset_n_i            (rst_n),
        .imem_req_o           (req),
        .imem_addr_o          (addr),
        .imem_gnt_i           (gnt),
        .imem_rvalid_i        (rvalid),
        .imem_rdata_i         (rdata),
        .instruction_o        (instr),
        .programCounter_o     (pc_out),
        .instr_valid_o        (valid),
        .instr_ready_i        (ready),
        .nextProgramCounter_i (npc),
        .fetch_err_o          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: granted requests and newly presented instructions against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req && gnt) begin
                if (addr_q.size() == 0) check("unexpected_grant", addr, 32'hFFFF_FFFF);
                else check("sb_req_addr", addr, addr_q.pop_front());
            end
            if (valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", instr, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_instr", instr, e.instr);
                    check("sb_pc", pc_out, e.pc);
                end
            end
        end
        prev_valid <= rst_n ? valid : 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input int gnt_dly, input int rv_dly,
                         input logic [31:0] data, input bit spur);
        int          n = 0;
        logic [31:0] held;
        held = instr;
        while (!req && n < 8) begin
            tick();
            n++;
        end
        check("req_seen", {31'd0, req}, 32'd1);
        for (int i = 0; i < gnt_dly; i++) begin
            check("addr_stable", addr, a);
            check("req_held", {31'd0, req}, 32'd1);
            rvalid = spur && (i == 0);
            rdata  = 32'hDEAD_BEEF;
            tick();
            rvalid = 1'b0;
            if (spur && i == 0) check("spur_fetch_instr", instr, held);
        end
        gnt = 1'b1;
        addr_q.push_back(a);
        tick();
        gnt = 1'b0;
        check("wait_no_req", {31'd0, req}, 32'd0);
        for (int i = 0; i < rv_dly; i++) tick();
        check("err_before_rvalid", {30'd0, err}, 32'd0);
        rvalid = 1'b1;
        rdata  = data;
        exp_q.push_back('{data, a});
        tick();
        rvalid = 1'b0;
        check("valid_after_rvalid", {31'd0, valid}, 32'd1);
    endtask

    task automatic hold_check(input int cycles);
        logic [31:0] si, sp;
        si = instr;
        sp = pc_out;
        for (int i = 0; i < cycles; i++) begin
            rvalid = (i == 3);
            rdata  = 32'hBAD0_BAD0;
            tick();
            rvalid = 1'b0;
            check("hold_valid", {31'd0, valid}, 32'd1);
            check("hold_no_req", {31'd0, req}, 32'd0);
            check("hold_instr", instr, si);
            check("hold_pc", pc_out, sp);
        end
    endtask

    task automatic retire(input logic [31:0] next);
        ready = 1'b1;
        npc   = next;
        tick();
        ready = 1'b0;
        check("retire_valid_low", {31'd0, valid}, 32'd0);
        if (next[1:0] == 2'b00) begin
            check("retire_req", {31'd0, req}, 32'd1);
            check("retire_addr", addr, next);
        end else begin
            check("misalign_err", {30'd0, err}, 32'd2);
            check("misalign_no_req", {31'd0, req}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_req", {31'd0, req}, 32'd1);
        check("post_reset_addr", addr, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0; npc = '0;
        tick();
        tick();
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_addr", addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_err", {30'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("first_req", {31'd0, req}, 32'd1);
        check("first_addr", addr, 32'h0);

        fetch(32'h0, 0, 0, 32'h2008_0005, 1'b0);
        hold_check(10);
        retire(32'h0000_0040);
        fetch(32'h40, 5, 0, 32'h1111_0001, 1'b1);
        retire(32'h0000_0044);
        fetch(32'h44, 0, 15, 32'h2222_0002, 1'b0);
        retire(32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 0, 0, 32'h3333_0003, 1'b0);
        retire(32'h0000_0000);
        fetch(32'h0, 0, 0, 32'h4444_0004, 1'b0);
        retire(32'h0000_0042);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("err_sticky_misalign", {30'd0, err}, 32'd2);
            check("err_no_req", {31'd0, req}, 32'd0);
            check("err_no_valid", {31'd0, valid}, 32'd0);
        end

        // Timeout: grant, then no response for the full window.
        do_reset();
        gnt = 1'b1;
        addr_q.push_back(32'h0);
        tick();
        gnt = 1'b0;
        repeat (15) tick();
        check("err_not_yet", {30'd0, err}, 32'd0);
        tick();
        check("timeout_err", {30'd0, err}, 32'd1);
        check("timeout_no_req", {31'd0, req}, 32'd0);
        rvalid = 1'b1;
        rdata  = 32'hBAD1_BAD1;
        tick();
        rvalid = 1'b0;
        check("late_rvalid_valid", {31'd0, valid}, 32'd0);
        check("late_rvalid_instr", instr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("timeout_sticky", {30'd0, err}, 32'd1);
            check("timeout_req_low", {31'd0, req}, 32'd0);
        end

        // Reset asserted asynchronously in WAIT, stale response afterwards.
        do_reset();
        fetch(32'h0, 0, 0, 32'h5555_0005, 1'b0);
        retire(32'h0000_0080);
        gnt = 1'b1;
        addr_q.push_back(32'h80);
        tick();
        gnt = 1'b0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_addr", addr, 32'h0);
        check("async_rst_instr", instr, 32'h0);
        check("async_rst_pc", pc_out, 32'h0);
        tick();
        rst_n  = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hBAD2_BAD2;
        tick();
        rvalid = 1'b0;
        check("fresh_req", {31'd0, req}, 32'd1);
        check("fresh_addr", addr, 32'h0);
        check("stale_instr", instr, 32'h0);
        check("stale_valid", {31'd0, valid}, 32'd0);
        fetch(32'h0, 0, 0, 32'h6666_0006, 1'b0);
        tick();

        check("sb_drained", exp_q.size() + addr_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
